lsu_port_arbiter: RTL and testbench

- Shares one ID-tagged memory request/response port among NumReq load-store units.
- Each LSU drives requests tagged with its own local ID.
- The arbiter grants requests round-robin and prefixes the requester index onto the outgoing ID.
- Responses are routed back by the index in the response ID's MSBs. The block sits between the per-core LSUs and the tile memory interconnect.

---
 rtl/lsu_port_arb_pkg.sv | 25 ++
 rtl/lsu_port_arb_rr_pick.sv | 34 +++
 rtl/lsu_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_lsu_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_port_arb_pkg.sv
// Shared definitions for the LSU port arbiter.
//   idx_width()   : bits needed to index n items (minimum 1)
//   req_payload_t : request fields muxed from the winning requester
//   Msg*          : assertion message strings
package lsu_port_arb_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
  } req_payload_t;

  localparam string MsgLockDrop     = "lsu_port_arb: locked requester dropped valid";
  localparam string MsgLockUnstable = "lsu_port_arb: locked requester changed payload";
  localparam string MsgUnderflow    = "lsu_port_arb: response for requester with no outstanding request";
  localparam string MsgOverflow     = "lsu_port_arb: request accepted beyond outstanding limit";
  localparam string MsgBadSel       = "lsu_port_arb: response ID selects nonexistent requester, dropped";

endpackage

// File: rtl/lsu_port_arb_rr_pick.sv
// Combinational rotating-priority picker.
//   eligible_i : per-requester eligibility
//   ptr_i      : index with highest priority this cycle (must be < NumReq)
//   winner_o   : first eligible index at or after ptr_i, wrapping
//   any_o      : at least one requester eligible
// The pointer register lives in the parent.
module lsu_port_arb_rr_pick
  import lsu_port_arb_pkg::*;
#(
  parameter  int NumReq   = 2,
  localparam int SelWidth = idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   eligible_i,
  input  logic [SelWidth-1:0] ptr_i,
  output logic [SelWidth-1:0] winner_o,
  output logic                any_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest eligible
  // index (smallest offset from ptr_i) is the last assignment.
  always_comb begin
    winner_o = '0;
    any_o    = |eligible_i;
    idx      = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (eligible_i[idx]) winner_o = SelWidth'(idx);
    end
  end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares one ID-tagged memory port among NumReq load-store units.
// Requests are granted round-robin (or fixed lowest-index priority when
// LSU_PORT_ARB_FIXED_PRIO_EN is defined); the winner's index is prefixed
// onto its local ID. Responses are routed back by the ID's index bits.
//
// Handshake: a transfer happens on a rising clk_i edge where valid && ready.
// Once a request is offered (out_qvalid_o) it is held on the same requester
// until accepted; that requester must keep valid and payload stable.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   in_q*_i / in_qready_o   per-requester request channels
//   in_p*_o / in_pready_i   per-requester response channels
//   out_q*_o / out_qready_i shared request channel, ID = {index, local ID}
//   out_p*_i / out_pready_o shared response channel
module lsu_port_arbiter
  import lsu_port_arb_pkg::*;
#(
  parameter  int NumReq         = 2,
  parameter  int IdWidth        = 2,
  parameter  int MaxOutstanding = 4,
  localparam int SelWidth       = idx_width(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0][31:0]          in_qaddr_i,
  input  logic [NumReq-1:0]                in_qwrite_i,
  input  logic [NumReq-1:0][3:0]           in_qamo_i,
  input  logic [NumReq-1:0][31:0]          in_qdata_i,
  input  logic [NumReq-1:0][3:0]           in_qstrb_i,
  input  logic [NumReq-1:0][IdWidth-1:0]   in_qid_i,
  input  logic [NumReq-1:0]                in_qvalid_i,
  output logic [NumReq-1:0]                in_qready_o,
  output logic [NumReq-1:0][31:0]          in_pdata_o,
  output logic [NumReq-1:0]                in_perror_o,
  output logic [NumReq-1:0][IdWidth-1:0]   in_pid_o,
  output logic [NumReq-1:0]                in_pvalid_o,
  input  logic [NumReq-1:0]                in_pready_i,
  output logic [31:0]                      out_qaddr_o,
  output logic                             out_qwrite_o,
  output logic [3:0]                       out_qamo_o,
  output logic [31:0]                      out_qdata_o,
  output logic [3:0]                       out_qstrb_o,
  output logic [SelWidth+IdWidth-1:0]      out_qid_o,
  output logic                             out_qvalid_o,
  input  logic                             out_qready_i,
  input  logic [31:0]                      out_pdata_i,
  input  logic                             out_perror_i,
  input  logic [SelWidth+IdWidth-1:0]      out_pid_i,
  input  logic                             out_pvalid_i,
  output logic                             out_pready_o
);

  localparam int CntWidth = idx_width(MaxOutstanding + 1);
  localparam int QidWidth = SelWidth + IdWidth;

  logic [NumReq-1:0][CntWidth-1:0] cnt_q;
  logic                            lock_q;
  logic [SelWidth-1:0]             lock_idx_q;
  logic [SelWidth-1:0]             rr_ptr;

  logic [NumReq-1:0]   eligible;
  logic [SelWidth-1:0] pick_idx;
  logic                pick_any;
  logic [SelWidth-1:0] winner;
  logic                q_hs;
  req_payload_t        win_payload;

  logic [SelWidth-1:0] sel;
  logic                sel_ok;
  logic                p_hs;
  logic [NumReq-1:0]   inc;
  logic [NumReq-1:0]   dec;

  // ---------------- request side ----------------
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = in_qvalid_i[i] && (cnt_q[i] != CntWidth'(MaxOutstanding));
    end
  end

  lsu_port_arb_rr_pick #(.NumReq(NumReq)) u_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr),
    .winner_o   (pick_idx),
    .any_o      (pick_any)
  );

  // A stalled offer stays with the captured requester until accepted.
  assign winner       = lock_q ? lock_idx_q : pick_idx;
  assign out_qvalid_o = lock_q | pick_any;
  assign q_hs         = out_qvalid_o & out_qready_i;

  always_comb begin
    win_payload.addr  = in_qaddr_i[winner];
    win_payload.write = in_qwrite_i[winner];
    win_payload.amo   = in_qamo_i[winner];
    win_payload.data  = in_qdata_i[winner];
    win_payload.strb  = in_qstrb_i[winner];
  end

  assign out_qaddr_o  = win_payload.addr;
  assign out_qwrite_o = win_payload.write;
  assign out_qamo_o   = win_payload.amo;
  assign out_qdata_o  = win_payload.data;
  assign out_qstrb_o  = win_payload.strb;
  assign out_qid_o    = {winner, in_qid_i[winner]};

  always_comb begin
    in_qready_o         = '0;
    in_qready_o[winner] = out_qvalid_o & out_qready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (q_hs) begin
      lock_q     <= 1'b0;
    end else if (out_qvalid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

`ifdef LSU_PORT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [SelWidth-1:0] rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (q_hs) begin
      rr_ptr_q <= (winner == SelWidth'(NumReq - 1)) ? '0 : winner + SelWidth'(1);
    end
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // ---------------- response side ----------------
  assign sel    = out_pid_i[QidWidth-1 -: SelWidth];
  assign sel_ok = (32'(sel) < NumReq);
  // Responses to a nonexistent requester are accepted and discarded.
  assign out_pready_o = sel_ok ? in_pready_i[sel] : 1'b1;
  assign p_hs         = out_pvalid_i & out_pready_o & sel_ok;

  always_comb begin
    in_pvalid_o = '0;
    if (sel_ok) in_pvalid_o[sel] = out_pvalid_i;
    for (int i = 0; i < NumReq; i++) begin
      in_pdata_o[i] = out_pdata_i;
      in_pid_o[i]   = out_pid_i[IdWidth-1:0];
    end
  end

  assign in_perror_o = {NumReq{out_perror_i}};

  // ---------------- outstanding counters ----------------
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      inc[i] = q_hs && (winner == SelWidth'(i));
      dec[i] = p_hs && (sel == SelWidth'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_lock_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> in_qvalid_i[lock_idx_q]) else $error("%s", MsgLockDrop);

  a_lock_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> ($stable(win_payload) && $stable(out_qid_o))) else $error("%s", MsgLockUnstable);

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    p_hs |-> (cnt_q[sel] != '0)) else $error("%s", MsgUnderflow);

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    q_hs |-> (cnt_q[winner] != CntWidth'(MaxOutstanding))) else $error("%s", MsgOverflow);

  a_sel_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_pvalid_i |-> sel_ok) else $error("%s", MsgBadSel);
`endif

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter with default parameters
// (NumReq=2, IdWidth=2, MaxOutstanding=4). Accepted requests are checked
// against an expected queue of {out_qid, addr[15:0]}.
module tb_lsu_port_arbiter;

  localparam int NumReq  = 2;
  localparam int IdWidth = 2;
  localparam int QidW    = 3;

  logic                           clk_i;
  logic                           rst_ni;
  logic [NumReq-1:0][31:0]        in_qaddr_i;
  logic [NumReq-1:0]              in_qwrite_i;
  logic [NumReq-1:0][3:0]         in_qamo_i;
  logic [NumReq-1:0][31:0]        in_qdata_i;
  logic [NumReq-1:0][3:0]         in_qstrb_i;
  logic [NumReq-1:0][IdWidth-1:0] in_qid_i;
  logic [NumReq-1:0]              in_qvalid_i;
  logic [NumReq-1:0]              in_qready_o;
  logic [NumReq-1:0][31:0]        in_pdata_o;
  logic [NumReq-1:0]              in_perror_o;
  logic [NumReq-1:0][IdWidth-1:0] in_pid_o;
  logic [NumReq-1:0]              in_pvalid_o;
  logic [NumReq-1:0]              in_pready_i;
  logic [31:0]                    out_qaddr_o;
  logic                           out_qwrite_o;
  logic [3:0]                     out_qamo_o;
  logic [31:0]                    out_qdata_o;
  logic [3:0]                     out_qstrb_o;
  logic [QidW-1:0]                out_qid_o;
  logic                           out_qvalid_o;
  logic                           out_qready_i;
  logic [31:0]                    out_pdata_i;
  logic                           out_perror_i;
  logic [QidW-1:0]                out_pid_i;
  logic                           out_pvalid_i;
  logic                           out_pready_o;

  lsu_port_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_qaddr_i   (in_qaddr_i),
    .in_qwrite_i  (in_qwrite_i),
    .in_qamo_i    (in_qamo_i),
    .in_qdata_i   (in_qdata_i),
    .in_qstrb_i   (in_qstrb_i),
    .in_qid_i     (in_qid_i),
    .in_qvalid_i  (in_qvalid_i),
    .in_qready_o  (in_qready_o),
    .in_pdata_o   (in_pdata_o),
    .in_perror_o  (in_perror_o),
    .in_pid_o     (in_pid_o),
    .in_pvalid_o  (in_pvalid_o),
    .in_pready_i  (in_pready_i),
    .out_qaddr_o  (out_qaddr_o),
    .out_qwrite_o (out_qwrite_o),
    .out_qamo_o   (out_qamo_o),
    .out_qdata_o  (out_qdata_o),
    .out_qstrb_o  (out_qstrb_o),
    .out_qid_o    (out_qid_o),
    .out_qvalid_o (out_qvalid_o),
    .out_qready_i (out_qready_i),
    .out_pdata_i  (out_pdata_i),
    .out_perror_i (out_perror_i),
    .out_pid_i    (out_pid_i),
    .out_pvalid_i (out_pvalid_i),
    .out_pready_o (out_pready_o)
  );

  // ---------------- clock ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge any accepted request is popped and
  // compared, then return just after the next rising edge.
  task automatic cycle();
    @(negedge clk_i);
    if (out_qvalid_o && out_qready_i) begin
      if (exp_q.size() == 0) chk("sb_unexpected_grant", 64'(exp_q.size()), 64'd1);
      else chk("sb_grant", 64'({out_qid_o, out_qaddr_o[15:0]}), 64'(exp_q.pop_front()));
    end
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input int i, input logic v, input logic [31:0] a, input logic [1:0] id);
    in_qvalid_i[i] = v;
    in_qaddr_i[i]  = a;
    in_qwrite_i[i] = a[8];
    in_qamo_i[i]   = a[3:0];
    in_qdata_i[i]  = ~a;
    in_qstrb_i[i]  = 4'hf;
    in_qid_i[i]    = id;
  endtask

  task automatic resp(input logic s, input logic [1:0] lid);
    out_pvalid_i = 1'b1;
    out_pid_i    = {s, lid};
    in_pready_i  = 2'b11;
    cycle();
    out_pvalid_i = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst_ni       = 1'b0;
    in_qaddr_i   = '0;
    in_qwrite_i  = '0;
    in_qamo_i    = '0;
    in_qdata_i   = '0;
    in_qstrb_i   = '0;
    in_qid_i     = '0;
    in_qvalid_i  = '0;
    in_pready_i  = '0;
    out_qready_i = 1'b0;
    out_pdata_i  = '0;
    out_perror_i = 1'b0;
    out_pid_i    = '0;
    out_pvalid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_qvalid", 64'(out_qvalid_o), 64'd0);
    chk("rst_qready", 64'(in_qready_o), 64'd0);
    chk("rst_pvalid", 64'(in_pvalid_o), 64'd0);
    chk("rst_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    chk("rst_cnt1", 64'(dut.cnt_q[1]), 64'd0);
    chk("rst_lock", 64'(dut.lock_q), 64'd0);
    rst_ni = 1'b1;
    cycle();

    // ---------------- single requester ----------------
    drive_req(1, 1'b1, 32'h100, 2'd2);
    out_qready_i = 1'b1;
    exp_q.push_back({3'b110, 16'h0100});
    #3;
    chk("single_qvalid", 64'(out_qvalid_o), 64'd1);
    chk("single_qid", 64'(out_qid_o), 64'h6);
    chk("single_qready", 64'(in_qready_o), 64'h2);
    chk("single_qaddr", 64'(out_qaddr_o), 64'h100);
    chk("single_qwrite", 64'(out_qwrite_o), 64'd1);
    cycle();
    drive_req(1, 1'b0, 32'h0, 2'd0);
    chk("single_cnt1_up", 64'(dut.cnt_q[1]), 64'd1);
    out_pvalid_i = 1'b1;
    out_pid_i    = 3'b110;
    out_pdata_i  = 32'hcafe_f00d;
    out_perror_i = 1'b1;
    in_pready_i  = 2'b11;
    #3;
    chk("single_pvalid", 64'(in_pvalid_o), 64'h2);
    chk("single_pid0", 64'(in_pid_o[0]), 64'd2);
    chk("single_pid1", 64'(in_pid_o[1]), 64'd2);
    chk("single_pready", 64'(out_pready_o), 64'd1);
    chk("single_pdata0", 64'(in_pdata_o[0]), 64'hcafef00d);
    chk("single_perror", 64'(in_perror_o), 64'h3);
    cycle();
    out_pvalid_i = 1'b0;
    out_perror_i = 1'b0;
    chk("single_cnt1_down", 64'(dut.cnt_q[1]), 64'd0);

    // ---------------- fairness ----------------
    drive_req(0, 1'b1, 32'h200, 2'd1);
    drive_req(1, 1'b1, 32'h300, 2'd3);
    exp_q.push_back({3'b001, 16'h0200});
    exp_q.push_back({3'b111, 16'h0300});
    exp_q.push_back({3'b001, 16'h0200});
    exp_q.push_back({3'b111, 16'h0300});
    repeat (4) cycle();
    drive_req(0, 1'b0, 32'h0, 2'd0);
    drive_req(1, 1'b0, 32'h0, 2'd0);
    chk("fair_cnt0", 64'(dut.cnt_q[0]), 64'd2);
    chk("fair_cnt1", 64'(dut.cnt_q[1]), 64'd2);
    resp(1'b0, 2'd1);
    resp(1'b0, 2'd1);
    resp(1'b1, 2'd3);
    resp(1'b1, 2'd3);
    chk("fair_drain0", 64'(dut.cnt_q[0]), 64'd0);

    // ---------------- lock ----------------
    out_qready_i = 1'b0;
    drive_req(0, 1'b1, 32'h400, 2'd0);
    drive_req(1, 1'b1, 32'h500, 2'd1);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("lock_qid_msb", 64'(out_qid_o[2]), 64'd0);
      chk("lock_qready", 64'(in_qready_o), 64'd0);
      cycle();
    end
    chk("lock_set", 64'(dut.lock_q), 64'd1);
    chk("lock_idx", 64'(dut.lock_idx_q), 64'd0);
    out_qready_i = 1'b1;
    exp_q.push_back({3'b000, 16'h0400});
    exp_q.push_back({3'b101, 16'h0500});
    #3;
    chk("lock_release_qready", 64'(in_qready_o), 64'h1);
    cycle();
    cycle();
    drive_req(0, 1'b0, 32'h0, 2'd0);
    drive_req(1, 1'b0, 32'h0, 2'd0);
    chk("lock_clear", 64'(dut.lock_q), 64'd0);
    resp(1'b0, 2'd0);
    resp(1'b1, 2'd1);

    // ---------------- credit limit ----------------
    for (int k = 0; k < 4; k++) begin
      drive_req(0, 1'b1, 32'h600 + 32'(k), 2'(k));
      exp_q.push_back({1'b0, 2'(k), 16'(16'h0600 + k)});
      cycle();
    end
    chk("credit_cnt0_full", 64'(dut.cnt_q[0]), 64'd4);
    drive_req(0, 1'b1, 32'h700, 2'd0);
    drive_req(1, 1'b1, 32'h800, 2'd2);
    exp_q.push_back({3'b110, 16'h0800});
    #3;
    chk("credit_qready", 64'(in_qready_o), 64'h2);
    chk("credit_req1_served", 64'(out_qid_o), 64'h6);
    cycle();
    drive_req(1, 1'b0, 32'h0, 2'd0);
    out_pvalid_i = 1'b1;
    out_pid_i    = 3'b000;
    in_pready_i  = 2'b11;
    #3;
    chk("credit_blocked_qvalid", 64'(out_qvalid_o), 64'd0);
    chk("credit_blocked_qready", 64'(in_qready_o), 64'd0);
    cycle();
    chk("credit_cnt0_after_resp", 64'(dut.cnt_q[0]), 64'd3);
    out_pid_i = 3'b001;
    exp_q.push_back({3'b000, 16'h0700});
    #3;
    chk("credit_reopen_qready", 64'(in_qready_o), 64'h1);
    cycle();
    chk("credit_same_cycle", 64'(dut.cnt_q[0]), 64'd3);
    out_pvalid_i = 1'b0;
    drive_req(0, 1'b1, 32'h704, 2'd3);
    exp_q.push_back({3'b011, 16'h0704});
    cycle();
    drive_req(0, 1'b0, 32'h0, 2'd0);
    chk("credit_cnt0_refill", 64'(dut.cnt_q[0]), 64'd4);
    repeat (4) resp(1'b0, 2'd0);
    resp(1'b1, 2'd2);
    chk("credit_drain0", 64'(dut.cnt_q[0]), 64'd0);
    chk("credit_drain1", 64'(dut.cnt_q[1]), 64'd0);

    // ---------------- response backpressure ----------------
    drive_req(1, 1'b1, 32'h900, 2'd0);
    exp_q.push_back({3'b100, 16'h0900});
    cycle();
    drive_req(1, 1'b0, 32'h0, 2'd0);
    out_pvalid_i = 1'b1;
    out_pid_i    = 3'b100;
    in_pready_i  = 2'b01;
    #3;
    chk("bp_pready_low", 64'(out_pready_o), 64'd0);
    chk("bp_pvalid", 64'(in_pvalid_o), 64'h2);
    cycle();
    chk("bp_cnt1_held", 64'(dut.cnt_q[1]), 64'd1);
    in_pready_i = 2'b10;
    #3;
    chk("bp_pready_high", 64'(out_pready_o), 64'd1);
    cycle();
    out_pvalid_i = 1'b0;
    chk("bp_cnt1_done", 64'(dut.cnt_q[1]), 64'd0);

    // ---------------- reset mid-burst ----------------
    for (int k = 0; k < 3; k++) begin
      drive_req(0, 1'b1, 32'ha00 + 32'(k), 2'(k));
      exp_q.push_back({1'b0, 2'(k), 16'(16'h0a00 + k)});
      cycle();
    end
    out_qready_i = 1'b0;
    drive_req(0, 1'b1, 32'hb00, 2'd3);
    cycle();
    chk("mid_lock_set", 64'(dut.lock_q), 64'd1);
    chk("mid_cnt0", 64'(dut.cnt_q[0]), 64'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    chk("mid_rst_lock", 64'(dut.lock_q), 64'd0);
    drive_req(1, 1'b1, 32'hc00, 2'd1);
    #1;
    chk("mid_rst_qvalid_follows", 64'(out_qvalid_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    // Pointer was 1 before reset; a reset pointer grants requester 0 first.
    out_qready_i = 1'b1;
    exp_q.push_back({3'b011, 16'h0b00});
    exp_q.push_back({3'b101, 16'h0c00});
    cycle();
    cycle();
    drive_req(0, 1'b0, 32'h0, 2'd0);
    drive_req(1, 1'b0, 32'h0, 2'd0);
    resp(1'b0, 2'd3);
    resp(1'b1, 2'd1);
    chk("end_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    chk("end_cnt1", 64'(dut.cnt_q[1]), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
